// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, 2-entry skid buffer, flush and MIPS field decode.
// Optional macro IFID_STALL_CNT_EN adds a saturating decode-stall counter output.
module ifid_skid_reg #(
  parameter int          PC_W    = 32,
  parameter logic [31:0] NOP_INS = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pcp4,
  input  logic [31:0]     in_ins,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pcp4,
`ifdef IFID_STALL_CNT_EN
  output logic [15:0]     stall_cnt,
`endif
  output logic [5:0]      op,
  output logic [4:0]      rs_fmt,
  output logic [4:0]      rt_ft,
  output logic [4:0]      rd_fs,
  output logic [4:0]      sh_fd,
  output logic [5:0]      fun,
  output logic [15:0]     im,
  output logic [25:0]     ad
);

  logic            main_valid;
  logic [PC_W-1:0] main_pcp4;
  logic [31:0]     main_ins;
  logic            skid_valid;
  logic [PC_W-1:0] skid_pcp4;
  logic [31:0]     skid_ins;
  logic            acc;
  logic            fire;

  // in_ready comes straight from a flop, so decode's out_ready never reaches fetch combinationally
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_pcp4  = main_pcp4;
  assign acc       = in_valid & in_ready;
  assign fire      = main_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_pcp4  <= '0;
      main_ins   <= NOP_INS;
      skid_valid <= 1'b0;
      skid_pcp4  <= '0;
      skid_ins   <= NOP_INS;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_pcp4  <= '0;
      main_ins   <= NOP_INS;
      skid_valid <= 1'b0;
      skid_pcp4  <= '0;
      skid_ins   <= NOP_INS;
    end else if (skid_valid) begin
      if (fire) begin
        main_pcp4  <= skid_pcp4;
        main_ins   <= skid_ins;
        skid_valid <= 1'b0;
      end
    end else if (main_valid) begin
      if (fire && acc) begin
        main_pcp4 <= in_pcp4;
        main_ins  <= in_ins;
      end else if (fire) begin
        main_valid <= 1'b0;
        main_ins   <= NOP_INS;
      end else if (acc) begin
        skid_valid <= 1'b1;
        skid_pcp4  <= in_pcp4;
        skid_ins   <= in_ins;
      end
    end else if (acc) begin
      main_valid <= 1'b1;
      main_pcp4  <= in_pcp4;
      main_ins   <= in_ins;
    end
  end

`ifdef IFID_STALL_CNT_EN
  // Counts held-but-not-taken cycles; sticks at all-ones and survives flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  assign op     = main_ins[31:26];
  assign rs_fmt = main_ins[25:21];
  assign rt_ft  = main_ins[20:16];
  assign rd_fs  = main_ins[15:11];
  assign sh_fd  = main_ins[10:6];
  assign fun    = main_ins[5:0];
  assign im     = main_ins[15:0];
  assign ad     = main_ins[25:0];

endmodule
